// File: rtl/rf_sched_pkg.sv
// rf_sched_pkg: shared register-file geometry and writeback requester indices
package rf_sched_pkg;
    localparam int NUM_REGS   = 32;
    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 32;
    localparam int REQ_ALU    = 0;
    localparam int REQ_LOAD   = 1;
    localparam int REQ_MULDIV = 2;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-wide one-hot arbiter, round-robin or fixed priority
//   clk, reset : clock, asynchronous active-high reset
//   req        : request vector
//   gnt        : one-hot grant, combinational from req and the pointer
//   Macro RF_WB_SCHED_RR_EN selects round-robin (pointer register present);
//   otherwise the lowest index wins and no state is kept.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
`ifdef RF_WB_SCHED_RR_EN
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    logic [PW-1:0] ptr, ptr_n;
    logic [N-1:0]  rot, pick;
    // Rotate so the pointer index sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot = N'({req, req} >> ptr);
        pick = rot & (~rot + N'(1));
        gnt = N'({pick, pick} >> (N - int'(ptr)));
        ptr_n = ptr;
        for (int i = 0; i < N; i++)
            if (gnt[i]) ptr_n = (i == N - 1) ? '0 : PW'(i + 1);
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) ptr <= '0;
        else ptr <= ptr_n;
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign gnt = req & (~req + N'(1));
`endif
endmodule

// File: rtl/rf_wb_sched.sv
// rf_wb_sched: register-file write-port scheduler with long-latency scoreboard
//   clk, reset           : clock, asynchronous active-high reset
//   req_valid/addr/data  : per-requester write requests (0=ALU, 1=load, 2=mul/div)
//   req_ready            : one-hot grant
//   rf_we/waddr/wdata    : registered write to the register file
//   iss_*                : issue-stage instruction fields; iss_stall holds issue
//   pending              : scoreboard of registers with a long write outstanding
//   Macro RF_WB_SCHED_RR_EN enables round-robin arbitration (default fixed priority).
module rf_wb_sched #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = rf_sched_pkg::DATA_W,
    parameter int ADDR_W  = rf_sched_pkg::ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    input  logic                      iss_valid,
    input  logic [ADDR_W-1:0]         iss_rs1,
    input  logic [ADDR_W-1:0]         iss_rs2,
    input  logic [ADDR_W-1:0]         iss_rd,
    input  logic                      iss_use_rs1,
    input  logic                      iss_use_rs2,
    input  logic                      iss_long,
    output logic                      iss_stall,
    output logic [31:0]               pending
);
    import rf_sched_pkg::*;
    logic [NUM_REQ-1:0]  gnt;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                wr_long;
    logic [NUM_REGS-1:0] set_vec, clr_vec;
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk  (clk),
        .reset(reset),
        .req  (req_valid),
        .gnt  (gnt)
    );
    assign req_ready = reset ? '0 : gnt;
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (req_ready[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
    end
    // wr_long remembers whether the staged write belongs to a scoreboarded requester.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            wr_long  <= 1'b0;
        end else begin
            rf_we <= |req_ready && sel_addr != '0;
            if (|req_ready) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
                wr_long  <= ~req_ready[REQ_ALU];
            end
        end
    // rd term blocks WAW: a younger long op must not overtake an outstanding one.
    assign iss_stall = iss_valid & ((iss_use_rs1 & pending[iss_rs1]) |
                                    (iss_use_rs2 & pending[iss_rs2]) | pending[iss_rd]);
    assign set_vec = (iss_valid & iss_long & ~iss_stall & iss_rd != '0) ? NUM_REGS'(1) << iss_rd : '0;
    assign clr_vec = (rf_we & wr_long) ? NUM_REGS'(1) << rf_waddr : '0;
    // Set is OR-ed after clear so a same-edge set wins.
    always_ff @(posedge clk or posedge reset)
        if (reset) pending <= '0;
        else pending <= ((pending & ~clr_vec) | set_vec) & ~NUM_REGS'(1);
endmodule

// File: tb/tb_rf_wb_sched.sv
// tb_rf_wb_sched: directed self-checking bench with write scoreboard for rf_wb_sched
module tb_rf_wb_sched;
    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic            iss_valid = 1'b0;
    logic [AW-1:0]   iss_rs1 = '0;
    logic [AW-1:0]   iss_rs2 = '0;
    logic [AW-1:0]   iss_rd = '0;
    logic            iss_use_rs1 = 1'b0;
    logic            iss_use_rs2 = 1'b0;
    logic            iss_long = 1'b0;
    logic            iss_stall;
    logic [31:0]     pending;
    wr_t             q[$];
    wr_t             e;
    int              checks = 0;
    int              failures = 0;
    logic [N-1:0]    exp_g[4];

    rf_wb_sched #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_use_rs1(iss_use_rs1), .iss_use_rs2(iss_use_rs2), .iss_long(iss_long),
        .iss_stall(iss_stall), .pending(pending)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // Scoreboard: each accepted non-x0 transfer must appear on the write port one cycle later.
    always @(negedge clk) begin
        #5;
        chk("sb_rf_we", rf_we, q.size() > 0);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_waddr", rf_waddr, e.a);
            chk("sb_wdata", rf_wdata, e.d);
        end
        for (int i = 0; i < N; i++)
            if (req_valid[i] && req_ready[i] && req_addr[i*AW +: AW] != '0)
                q.push_back({req_addr[i*AW +: AW], req_data[i*DW +: DW]});
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
`ifdef RF_WB_SCHED_RR_EN
        exp_g = '{3'b100, 3'b001, 3'b100, 3'b001};
`else
        exp_g = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
        #1 reset = 1'b1;
        set_req(0, 1'b1, 5'd1, 32'h1);
        set_req(1, 1'b1, 5'd2, 32'h2);
        set_req(2, 1'b1, 5'd3, 32'h3);
        iss_valid = 1'b1; iss_use_rs1 = 1'b1; iss_rs1 = 5'd3;
        @(negedge clk); #5;
        chk("rst_ready", req_ready, 3'b000);
        chk("rst_we", rf_we, 1'b0);
        chk("rst_waddr", rf_waddr, 5'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_stall", iss_stall, 1'b0);
        @(negedge clk);
        reset = 1'b0; req_valid = '0; iss_valid = 1'b0; iss_use_rs1 = 1'b0;
        // single load write
        @(negedge clk); set_req(1, 1'b1, 5'd5, 32'hDEADBEEF); #5;
        chk("load_ready", req_ready, 3'b010);
        @(negedge clk); req_valid = '0; #5;
        chk("load_we", rf_we, 1'b1);
        chk("load_waddr", rf_waddr, 5'd5);
        chk("load_wdata", rf_wdata, 32'hDEADBEEF);
        // ALU vs mul/div contention; pointer sits at 2 after the load grant
        @(negedge clk);
        set_req(0, 1'b1, 5'd3, 32'hA0A0A0A0);
        set_req(2, 1'b1, 5'd4, 32'hC2C2C2C2);
        #5; chk("cont_g0", req_ready, exp_g[0]);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk); #5;
            chk("cont_g", req_ready, exp_g[k]);
        end
        @(negedge clk); req_valid = '0; #5;
        // write to x0
        @(negedge clk); set_req(0, 1'b1, 5'd0, 32'h55); #5;
        chk("x0_ready", req_ready, 3'b001);
        @(negedge clk); req_valid = '0; #5;
        chk("x0_we", rf_we, 1'b0);
        // long op to x7, then WAW and RAW consumers
        @(negedge clk); iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd7; #5;
        chk("long7_stall", iss_stall, 1'b0);
        @(negedge clk); iss_long = 1'b0; #5;
        chk("waw_pending", pending, 32'h80);
        chk("waw_stall", iss_stall, 1'b1);
        @(negedge clk); iss_rd = 5'd8; iss_rs1 = 5'd7; iss_use_rs1 = 1'b1; #5;
        chk("raw_stall0", iss_stall, 1'b1);
        @(negedge clk); set_req(2, 1'b1, 5'd7, 32'h77777777); #5;
        chk("md_ready", req_ready, 3'b100);
        chk("raw_stall1", iss_stall, 1'b1);
        @(negedge clk); req_valid = '0; #5;
        chk("raw_stall2", iss_stall, 1'b1);
        chk("raw_pending2", pending, 32'h80);
        @(negedge clk); #5;
        chk("raw_stall3", iss_stall, 1'b0);
        chk("raw_pending3", pending, 32'h0);
        @(negedge clk); iss_valid = 1'b0; iss_use_rs1 = 1'b0;
        // same-edge set and clear of x9
        set_req(1, 1'b1, 5'd9, 32'h99); #5;
        chk("x9_ready", req_ready, 3'b010);
        @(negedge clk); req_valid = '0; iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd9; #5;
        chk("x9_stall", iss_stall, 1'b0);
        @(negedge clk); iss_valid = 1'b0; iss_long = 1'b0; #5;
        chk("x9_set_wins", pending, 32'h200);
        @(negedge clk); set_req(1, 1'b1, 5'd9, 32'h1234); #5;
        @(negedge clk); req_valid = '0; #5;
        @(negedge clk); #5;
        chk("x9_cleared", pending, 32'h0);
        // reset while a write is staged and x7 is pending
        @(negedge clk); iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd7; #5;
        @(negedge clk); iss_valid = 1'b0; iss_long = 1'b0; set_req(0, 1'b1, 5'd10, 32'hABCD0123); #5;
        chk("pre_rst_pending", pending, 32'h80);
        @(negedge clk); req_valid = '0; #5;
        chk("pre_rst_we", rf_we, 1'b1);
        #2 reset = 1'b1; q.delete();
        #1;
        chk("mid_rst_we", rf_we, 1'b0);
        chk("mid_rst_pending", pending, 32'h0);
        chk("mid_rst_waddr", rf_waddr, 5'd0);
        @(negedge clk); reset = 1'b0; #5;
        chk("post_rst_we", rf_we, 1'b0);
        // pointer back at 0 after reset
        @(negedge clk);
        set_req(0, 1'b1, 5'd11, 32'h0B0B0B0B);
        set_req(2, 1'b1, 5'd12, 32'h0C0C0C0C);
        #5; chk("post_rst_g0", req_ready, 3'b001);
        @(negedge clk); #5;
`ifdef RF_WB_SCHED_RR_EN
        chk("post_rst_g1", req_ready, 3'b100);
`else
        chk("post_rst_g1", req_ready, 3'b001);
`endif
        @(negedge clk); req_valid = '0; #5;
        @(negedge clk); #5;
        chk("sb_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rf_wb_sched.md
# rf_wb_sched

Writeback scheduler and scoreboard for the 32×32 register file in the pipelined RISC-V core. It shares the file's single write port among several writeback requesters: the ALU pipe, the load unit and the multi-cycle mul/div. It also tracks destination registers that have a long-latency write outstanding. From that tracking it drives an issue-stage stall for RAW and WAW hazards. It sits between the execute/memory units and the register file's RegWrite/write_addr/write_data inputs.

## Interface
Parameters:
- NUM_REQ, 3, number of writeback requesters (index 0 = ALU, 1 = load, 2 = mul/div).
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  NUM_REQ  requester i has a write pending.
- req_addr  in  NUM_REQ*ADDR_W  destination of requester i, slice i.
- req_data  in  NUM_REQ*DATA_W  write data of requester i, slice i.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid&ready.
- rf_we  out  1  register-file write enable (RegWrite).
- rf_waddr  out  ADDR_W  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- iss_valid  in  1  instruction present in the issue stage.
- iss_rs1, iss_rs2, iss_rd  in  ADDR_W  each  source and destination registers of the issuing instruction.
- iss_use_rs1, iss_use_rs2  in  1  each  the corresponding source is read.
- iss_long  in  1  the issuing instruction writes rd through requester 1 or 2.
- iss_stall  out  1  hold the issue stage.
- pending  out  32  scoreboard vector (debug/observability).

## Operation
- Arbitration:
  - Each cycle, at most one req_ready bit is asserted, and only for a requester with req_valid.
  - req_ready is combinational from req_valid and the arbiter state.
  - A requester holds req_valid, req_addr and req_data stable until it is granted.
- Write pipeline stage: a granted transfer is captured into the registered stage (rf_we/rf_waddr/rf_wdata).
  - rf_we=1 only if the captured address ≠ 0.
  - Writes to x0 are accepted (ready asserted) but never drive rf_we.
- Scoreboard set:
  - When iss_valid & iss_long & ~iss_stall & iss_rd≠0, pending[iss_rd] is set on the next edge.
  - pending[0] is always 0.
- Scoreboard clear: on the edge where rf_we=1 commits a write from requester 1 or 2, pending[rf_waddr] is cleared. ALU writes never touch the scoreboard.
- Simultaneous set and clear of the same bit: set wins.
- iss_stall = iss_valid & ((iss_use_rs1 & pending[iss_rs1]) | (iss_use_rs2 & pending[iss_rs2]) | pending[iss_rd]). This is combinational. The iss_rd term covers WAW.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, pending=0, arbiter pointer=0. req_ready and iss_stall are 0 while reset is asserted.
- Latency:
  - Grant at edge N produces rf_we high during cycle N+1. The register file commits the write at edge N+2.
  - The pending bit clears at that same edge N+2, so iss_stall drops in cycle N+2 and the consumer reads the committed value.
- Throughput: one write per cycle. With no contention there are no bubbles.
- Reset mid-operation: the in-flight registered write is discarded and all pending bits clear.

## Configuration
- RF_WB_SCHED_RR_EN:
  - Defined: round-robin arbitration. After granting i, the next search starts at i+1 (mod NUM_REQ).
  - Undefined: fixed priority, where the lowest index wins (ALU highest), and the pointer register is not instantiated.

## Structure
- Package rf_sched_pkg:
  - NUM_REGS=32, ADDR_W, DATA_W.
  - Requester index constants REQ_ALU=0, REQ_LOAD=1, REQ_MULDIV=2.
- One sub-module: rr_arbiter, a NUM_REQ-wide one-hot arbiter holding the rotating pointer. Its fixed/round-robin behaviour is selected by the macro.

## Test plan
- Reset, then load valid with addr=5, data=0xDEADBEEF → ready[1] asserted. Next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
- ALU and mul/div valid every cycle with RR enabled → grants alternate 0,2,0,2. With RR disabled → grant 0 continuously and mul/div starves.
- Request to x0 → req_ready=1 and rf_we stays 0.
- Issue long op with rd=7, then an instruction with rs1=7 → iss_stall=1 until the cycle after the mul/div write to x7 commits, then 0.
- Issue-set and writeback-clear of x9 on the same edge → pending[9] remains 1.
- Assert reset while rf_we=1 and pending=0x80 → rf_we=0 and pending=0 immediately; no write reaches the register file.
